// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - state encoding and counter sizing shared by the shift/add multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} mult_state_t;

  // Iteration counter must reach WIDTH-1; never narrower than one bit.
  function automatic int count_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_sub_n.sv
// rtl/add_sub_n.sv - N-bit ripple adder/subtractor (A + B, or A - B when subtract=1)
module add_sub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         subtract,
  output logic [N-1:0] Sum
);

  logic [N-1:0] b_eff;
  logic [N-1:0] carry;

  assign b_eff    = B ^ {N{subtract}};
  assign carry[0] = subtract;

  genvar i;
  generate
    for (i = 0; i < N - 1; i++) begin : g_fa
      full_adder u_fa (
        .a    (A[i]),
        .b    (b_eff[i]),
        .cin  (carry[i]),
        .sum  (Sum[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  // Callers pre-extend operands by one bit, so the final carry out is never needed.
  assign Sum[N-1] = A[N-1] ^ b_eff[N-1] ^ carry[N-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell for the ripple add/subtract unit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential signed add/subtract-and-shift multiplier
// Optional MULT_UNSIGNED_MODE_EN adds an is_signed input selecting unsigned operation.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   S_in,
  input  logic [WIDTH-1:0]   B_in,
`ifdef MULT_UNSIGNED_MODE_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic               X,
  output logic [2*WIDTH-1:0] Product
);

  localparam int COUNT_W = count_w(WIDTH);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

  mult_state_t        state, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, s_reg;
  logic               x_reg;
  logic [COUNT_W-1:0] count;
  logic               mode_signed;
  logic               last_iter;
  logic               shift_in;
  logic [WIDTH:0]     op_a, op_s, sum;

`ifdef MULT_UNSIGNED_MODE_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      mode_signed <= 1'b0;
    else if (state == LOAD)
      mode_signed <= is_signed;
  end
`else
  assign mode_signed = 1'b1;
`endif

  assign last_iter = (count == LAST);
  assign op_a      = {mode_signed & a_reg[WIDTH-1], a_reg};
  assign op_s      = {mode_signed & s_reg[WIDTH-1], s_reg};
  // Unsigned shifts must bring in zero even when X still holds a previous carry.
  assign shift_in  = mode_signed & x_reg;

  add_sub_n #(.N(WIDTH + 1)) u_add_sub (
    .A        (op_a),
    .B        (op_s),
    .subtract (mode_signed & last_iter),
    .Sum      (sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (Run) state_next = LOAD;
      LOAD: begin
        busy       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      x_reg <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        LOAD: begin
          s_reg <= S_in;
          b_reg <= B_in;
          a_reg <= '0;
          x_reg <= 1'b0;
          count <= '0;
        end
        ITER: begin
          if (b_reg[0])
            {x_reg, a_reg, b_reg} <= {sum[WIDTH], sum, b_reg[WIDTH-1:1]};
          else
            {x_reg, a_reg, b_reg} <= {x_reg, shift_in, a_reg, b_reg[WIDTH-1:1]};
          count <= count + COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign X       = x_reg;
  assign Product = {a_reg, b_reg};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Run;
  logic [W-1:0]   S_in;
  logic [W-1:0]   B_in;
  logic           busy;
  logic           done;
  logic           X;
  logic [2*W-1:0] Product;
`ifdef MULT_UNSIGNED_MODE_EN
  logic           is_signed;
`endif

  int total = 0;
  int bad   = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .S_in      (S_in),
    .B_in      (B_in),
`ifdef MULT_UNSIGNED_MODE_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .X         (X),
    .Product   (Product)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts an operation and waits (bounded) for done; n = edges until done, -1 on timeout.
  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] b,
                       output int n, output bit busy_ok);
    S_in    = s;
    B_in    = b;
    Run     = 1'b1;
    n       = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (!done) n = -1;
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run   = 1'b0;
    S_in  = '0;
    B_in  = '0;
    tick();
    tick();
    total++; if (Product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h want=%h", Product, 16'h0000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (X !== 1'b0) begin bad++; $display("FAIL reset_x got=%b want=0", X); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_signed_basic();
    int n;
    bit bo;
    do_op(8'h07, 8'hC5, n, bo);
    total++; if (Product !== 16'hFE63) begin bad++; $display("FAIL basic_product got=%h want=%h", Product, 16'hFE63); end
    total++; if (n !== W + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", n, W + 2); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bo); end
    total++; if (X !== 1'b1) begin bad++; $display("FAIL basic_x got=%b want=1", X); end
    release_run();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_idle_done got=%b want=0", done); end
    total++; if (Product !== 16'hFE63) begin bad++; $display("FAIL basic_retain got=%h want=%h", Product, 16'hFE63); end
    tick();
  endtask

  task automatic test_corners();
    logic [W-1:0]   sv [7] = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'h7F, 8'h5A, 8'h00};
    logic [W-1:0]   bv [7] = '{8'h80, 8'hFF, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'h80};
    logic [2*W-1:0] pv [7] = '{16'h4000, 16'h0001, 16'h3F01, 16'hC080, 16'hC080, 16'h0000, 16'h0000};
    int n;
    bit bo;
    for (int i = 0; i < 7; i++) begin
      do_op(sv[i], bv[i], n, bo);
      total++; if (Product !== pv[i]) begin bad++; $display("FAIL corner%0d_product got=%h want=%h", i, Product, pv[i]); end
      total++; if (X !== pv[i][2*W-1]) begin bad++; $display("FAIL corner%0d_x got=%b want=%b", i, X, pv[i][2*W-1]); end
      release_run();
    end
  endtask

  task automatic test_run_held();
    int  rises = 0;
    logic prev;
    int  n;
    bit  bo;
    S_in = 8'h07;
    B_in = 8'hC5;
    Run  = 1'b1;
    prev = busy;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy && !prev) rises++;
      prev = busy;
      if (i == 4) begin
        S_in = 8'h11;
        B_in = 8'h22;
      end
    end
    total++; if (rises !== 1) begin bad++; $display("FAIL held_ops got=%0d want=1", rises); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done got=%b want=1", done); end
    total++; if (Product !== 16'hFE63) begin bad++; $display("FAIL held_product got=%h want=%h", Product, 16'hFE63); end
    Run = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL held_idle got=%b%b want=00", busy, done); end
    do_op(8'h03, 8'h05, n, bo);
    total++; if (Product !== 16'h000F) begin bad++; $display("FAIL second_product got=%h want=%h", Product, 16'h000F); end
    total++; if (n !== W + 2) begin bad++; $display("FAIL second_latency got=%0d want=%0d", n, W + 2); end
    release_run();
  endtask

  task automatic test_reset_mid_iter();
    int n;
    bit bo;
    S_in = 8'h07;
    B_in = 8'hC5;
    Run  = 1'b1;
    repeat (6) tick();
    Reset = 1'b1;
    Run   = 1'b0;
    tick();
    total++; if (Product !== 16'h0000) begin bad++; $display("FAIL midreset_product got=%h want=%h", Product, 16'h0000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
    Reset = 1'b0;
    tick();
    do_op(8'hF9, 8'h0C, n, bo);
    total++; if (Product !== 16'hFFAC) begin bad++; $display("FAIL after_reset_product got=%h want=%h", Product, 16'hFFAC); end
    total++; if (n !== W + 2) begin bad++; $display("FAIL after_reset_latency got=%0d want=%0d", n, W + 2); end
    release_run();
  endtask

`ifdef MULT_UNSIGNED_MODE_EN
  task automatic test_unsigned();
    int n;
    bit bo;
    is_signed = 1'b0;
    do_op(8'hFF, 8'hFF, n, bo);
    total++; if (Product !== 16'hFE01) begin bad++; $display("FAIL unsigned_ffff got=%h want=%h", Product, 16'hFE01); end
    release_run();
    do_op(8'hFF, 8'h7F, n, bo);
    total++; if (Product !== 16'h7E81) begin bad++; $display("FAIL unsigned_ff7f got=%h want=%h", Product, 16'h7E81); end
    release_run();
    is_signed = 1'b1;
    do_op(8'hFF, 8'hFF, n, bo);
    total++; if (Product !== 16'h0001) begin bad++; $display("FAIL signed_ffff got=%h want=%h", Product, 16'h0001); end
    release_run();
  endtask
`endif

  initial begin
`ifdef MULT_UNSIGNED_MODE_EN
    is_signed = 1'b1;
`endif
    test_reset();
    test_signed_basic();
    test_corners();
    test_run_held();
    test_reset_mid_iter();
`ifdef MULT_UNSIGNED_MODE_EN
    test_unsigned();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
